mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- Parametrised successor to the memory-stage decoder.
- Accepts one instruction per handshake from execute: inst, effective address and store data/ALU result.
- Decodes all RISC-V load/store widths and signedness, and generates byte enables and lane-aligned write data.
- Drives a request/acknowledge data-memory port, then presents a sign/zero-extended writeback result to the writeback stage under valid/ready.

Parameters:
- XLEN, 32, datapath width. Legal values are 32 and 64. At 64, LD/SD/LWU are decoded.
- ADDR_W, 32, byte-address width of addr and mem_addr.
- BE_W, XLEN/8, byte-enable width. Derived; must not be overridden.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  block accepts the instruction this cycle
- inst  in  32  instruction word
- addr  in  ADDR_W  effective address (loads/stores) or don't-care
- wdata  in  XLEN  store data, or ALU result for non-memory instructions
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write (store), 0 = read
- mem_addr  out  ADDR_W  address with the low log2(BE_W) bits forced to 0
- mem_be  out  BE_W  byte enables
- mem_wdata  out  XLEN  lane-replicated store data
- mem_ack  in  1  memory completes the request; mem_rdata is valid on the same cycle
- mem_rdata  in  XLEN  read data
- out_valid  out  1  writeback payload valid
- out_ready  in  1  writeback accepts the payload
- out_inst  out  32  registered instruction
- out_rd  out  5  inst[11:7]
- out_rd_we  out  1  register-write enable
- out_data  out  XLEN  extended load data or passed-through result
- out_exc  out  1  misaligned-access flag (see Optional Feature)

Behaviour:
- States: IDLE, BUSY, HOLD. Reset forces IDLE.
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, out_valid=0, out_inst=0, out_rd=0, out_rd_we=0, out_data=0, out_exc=0.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Registered state only; no combinational path from in_valid.
- Accept occurs when in_valid && in_ready; inst, addr and wdata are captured.
- Non-memory accept: next cycle out_valid=1 and out_data=wdata. out_rd_we=1 unless opcode is BRANCH, STORE or MISC-MEM, or rd==0. State stays IDLE, giving 1-cycle latency.
- Load/store accept: next cycle state=BUSY and mem_req=1. mem_we, mem_addr, mem_be and mem_wdata are held stable until mem_ack.
- BUSY with mem_ack: mem_req drops on the next edge.
  - Load: out_data is the lane at addr[log2(BE_W)-1:0], sign-extended for LB/LH/LW and zero-extended for LBU/LHU/LWU; out_rd_we=(rd!=0).
  - Store: out_rd_we=0.
  - out_valid=1; state goes to HOLD if out_ready=0, else to IDLE.
- Minimum memory latency is 2 cycles from accept to out_valid, when mem_ack arrives in the first BUSY cycle.
- HOLD: payload is held stable until out_ready, then state=IDLE and out_valid drops unless a new accept loads it.
- Byte enables:
  - SB: one bit at the offset.
  - SH: 2 bits.
  - SW: 4 bits.
  - SD: all 8 bits.
  - At XLEN=32, width encodings of 64 bits or more decode as word.
- Store data is replicated across all lanes of the access width.
- Unknown funct3 on a load or store decodes as word.
- mem_ack while IDLE or HOLD is ignored.
- Reset mid-BUSY: mem_req=0 on the next edge. An in-flight ack is discarded.
- out_ready asserted while out_valid=0 has no effect.

Optional Feature:
- Macro: MEM_STAGE_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned accesses are halfword with addr[0]!=0, word with addr[1:0]!=0, or dword with addr[2:0]!=0.
  - A misaligned access issues no mem_req.
  - Next cycle out_valid=1, out_exc=1, out_rd_we=0, out_data=addr zero-extended to XLEN. State goes to HOLD/IDLE per out_ready.
- Undefined: out_exc is tied 0. The access proceeds aligned-down, with the offset truncated to the access width, and byte enables never straddle a word.

Decomposition:
- Package/header mem_pkg holds:
  - the state encoding IDLE/BUSY/HOLD;
  - opcode constants LOAD, STORE, BRANCH, MISC_MEM;
  - funct3 constants LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD;
  - MEM_READ/MEM_WRITE.
- Sub-module mem_lane_align (combinational) takes funct3, offset, wdata and rdata, and returns be, replicated wdata, extended rdata and the misaligned flag.

Test Plan:
- LB, addr=0x1003, mem_rdata=0x80FF_FF00, ack in the first BUSY cycle -> mem_addr=0x1000, mem_be=4'b1000, out_data=0xFFFF_FF80, out_valid exactly 2 cycles after accept.
- SH, addr=0x2002, wdata=0x0000_BEEF -> mem_we=1, mem_be=4'b1100, mem_wdata=0xBEEF_BEEF, out_rd_we=0.
- ADD result wdata=0x1234, rd=5, out_ready=1 -> out_valid one cycle later, out_data=0x1234, out_rd_we=1, mem_req never asserted.
- LW with ack delayed 4 cycles and out_ready=0 for 3 further cycles -> mem_req high through ack, payload stable in HOLD, in_ready=0 throughout.
- Reset asserted in the 2nd BUSY cycle, ack the following cycle -> all outputs 0, out_valid never rises, in_ready=1 after reset deasserts.
- MEM_STAGE_MISALIGN_TRAP_EN defined, LW addr=0x3002 -> no mem_req, out_exc=1, out_data=0x3002. With the macro undefined -> mem_addr=0x3000, mem_be=4'b1111.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the memory stage: FSM states, RISC-V opcodes/funct3 and access sizing.
package mem_pkg;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, HOLD = 2'd2} state_t;
    typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} size_t;

    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] MISC_MEM = 7'b0001111;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LD  = 3'd3;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;
    localparam logic [2:0] LWU = 3'd6;
    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;
    localparam logic [2:0] SD  = 3'd3;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    // Anything not legal for the configured width falls back to a word access.
    function automatic size_t accessSize(input logic [2:0] funct3, input logic store, input logic wide);
        size_t size;
        size = SZ_W;
        if (store) begin
            case (funct3)
                SB:      size = SZ_B;
                SH:      size = SZ_H;
                SW:      size = SZ_W;
                SD:      size = wide ? SZ_D : SZ_W;
                default: size = SZ_W;
            endcase
        end else begin
            case (funct3)
                LB, LBU: size = SZ_B;
                LH, LHU: size = SZ_H;
                LW, LWU: size = SZ_W;
                LD:      size = wide ? SZ_D : SZ_W;
                default: size = SZ_W;
            endcase
        end
        return size;
    endfunction

    function automatic logic isUnsignedLoad(input logic [2:0] funct3, input logic store, input logic wide);
        return !store && (funct3 == LBU || funct3 == LHU || (funct3 == LWU && wide));
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables, replicated store data, extended load data, misalign flag.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int BE_W = XLEN / 8,
    localparam int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [2:0]       funct3,
    input  logic             store,
    input  logic [OFF_W-1:0] offset,
    input  logic [XLEN-1:0]  wdata,
    input  logic [XLEN-1:0]  rdata,
    output logic [BE_W-1:0]  be,
    output logic [XLEN-1:0]  wdataRep,
    output logic [XLEN-1:0]  rdataExt,
    output logic             misaligned
);

    localparam logic WIDE = (XLEN == 64);

    size_t            size;
    logic [OFF_W-1:0] lane;
    logic [XLEN-1:0]  shifted;
    logic [XLEN-1:0]  upper;
    logic [6:0]       shamt;

    // Offsets are truncated to the access width so enables always stay inside one aligned unit.
    always_comb begin
        size       = accessSize(funct3, store, WIDE);
        lane       = '0;
        be         = '1;
        wdataRep   = wdata;
        misaligned = 1'b0;
        shamt      = 7'd0;
        case (size)
            SZ_B: begin
                lane     = offset;
                be       = BE_W'(1) << offset;
                wdataRep = {BE_W{wdata[7:0]}};
                shamt    = 7'(XLEN - 8);
            end
            SZ_H: begin
                lane       = offset & ~OFF_W'(1);
                be         = BE_W'(3) << lane;
                wdataRep   = {(BE_W / 2){wdata[15:0]}};
                misaligned = offset[0];
                shamt      = 7'(XLEN - 16);
            end
            SZ_W: begin
                lane       = offset & ~OFF_W'(3);
                be         = BE_W'(15) << lane;
                wdataRep   = {(BE_W / 4){wdata[31:0]}};
                misaligned = |offset[1:0];
                shamt      = 7'(XLEN - 32);
            end
            default: begin
                lane       = '0;
                be         = '1;
                wdataRep   = wdata;
                misaligned = |offset;
                shamt      = 7'd0;
            end
        endcase
        shifted = rdata >> {lane, 3'b000};
        upper   = shifted << shamt;
        if (isUnsignedLoad(funct3, store, WIDE))
            rdataExt = upper >> shamt;
        else
            rdataExt = $signed(upper) >>> shamt;
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: execute handshake, req/ack data port, valid/ready writeback.
// Optional build macro MEM_STAGE_MISALIGN_TRAP_EN turns misaligned accesses into exceptions.
module mem_stage_ctrl
    import mem_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ADDR_W = 32,
    localparam int BE_W = XLEN / 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       inst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BE_W-1:0]   mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [4:0]        out_rd,
    output logic              out_rd_we,
    output logic [XLEN-1:0]   out_data,
    output logic              out_exc
);

    localparam int OFF_W = $clog2(BE_W);

    state_t           state;
    logic [31:0]      curInst;
    logic [2:0]       curF3;
    logic             curStore;
    logic [OFF_W-1:0] curOff;

    logic             isLoad, isStoreOp, isMem, accept, trap;
    logic [2:0]       alF3;
    logic             alStore;
    logic [OFF_W-1:0] alOff;
    logic [BE_W-1:0]  alBe;
    logic [XLEN-1:0]  alWdata, alRdata;
    logic             alMis;

    assign isLoad    = (inst[6:0] == LOAD);
    assign isStoreOp = (inst[6:0] == STORE);
    assign isMem     = isLoad || isStoreOp;
    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;

    // The aligner sees the incoming instruction while idle and the captured one while waiting on memory.
    assign alF3    = (state == IDLE) ? inst[14:12]           : curF3;
    assign alStore = (state == IDLE) ? isStoreOp             : curStore;
    assign alOff   = (state == IDLE) ? addr[OFF_W-1:0]       : curOff;

    mem_lane_align #(.XLEN(XLEN)) align (
        .funct3    (alF3),
        .store     (alStore),
        .offset    (alOff),
        .wdata     (wdata),
        .rdata     (mem_rdata),
        .be        (alBe),
        .wdataRep  (alWdata),
        .rdataExt  (alRdata),
        .misaligned(alMis)
    );

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    assign trap = alMis;
`else
    // Misaligned accesses simply proceed aligned-down, so the flag is never acted on.
    assign trap = alMis & 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            curInst   <= '0;
            curF3     <= '0;
            curStore  <= 1'b0;
            curOff    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= MEM_READ;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_rd    <= '0;
            out_rd_we <= 1'b0;
            out_data  <= '0;
            out_exc   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (out_valid && out_ready)
                        out_valid <= 1'b0;
                    if (accept) begin
                        curInst  <= inst;
                        curF3    <= inst[14:12];
                        curStore <= isStoreOp;
                        curOff   <= addr[OFF_W-1:0];
                        if (isMem && trap) begin
                            out_valid <= 1'b1;
                            out_exc   <= 1'b1;
                            out_rd_we <= 1'b0;
                            out_data  <= XLEN'(addr);
                            out_inst  <= inst;
                            out_rd    <= inst[11:7];
                        end else if (isMem) begin
                            state     <= BUSY;
                            mem_req   <= 1'b1;
                            mem_we    <= isStoreOp ? MEM_WRITE : MEM_READ;
                            mem_addr  <= {addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                            mem_be    <= alBe;
                            mem_wdata <= alWdata;
                        end else begin
                            out_valid <= 1'b1;
                            out_exc   <= 1'b0;
                            out_data  <= wdata;
                            out_inst  <= inst;
                            out_rd    <= inst[11:7];
                            out_rd_we <= !(inst[6:0] == BRANCH || inst[6:0] == STORE ||
                                           inst[6:0] == MISC_MEM) && (inst[11:7] != 5'd0);
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        out_valid <= 1'b1;
                        out_exc   <= 1'b0;
                        out_inst  <= curInst;
                        out_rd    <= curInst[11:7];
                        out_rd_we <= !curStore && (curInst[11:7] != 5'd0);
                        out_data  <= curStore ? '0 : alRdata;
                        state     <= out_ready ? IDLE : HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl (XLEN=32): directed cases then randomized transactions.
module tb_mem_stage_ctrl;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_FENCE = 7'b0001111;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [31:0] inst, addr, wdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        out_valid, out_ready, out_rd_we, out_exc;
    logic [31:0] out_inst, out_data;
    logic [4:0]  out_rd;

    int compared = 0;
    int mismatched = 0;

    mem_stage_ctrl #(.XLEN(32), .ADDR_W(32)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .addr(addr), .wdata(wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_rd(out_rd),
        .out_rd_we(out_rd_we), .out_data(out_data), .out_exc(out_exc)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_mem_req"}, 64'(mem_req), 0);
        checkOutput({tag, "_mem_we"}, 64'(mem_we), 0);
        checkOutput({tag, "_mem_addr"}, 64'(mem_addr), 0);
        checkOutput({tag, "_mem_be"}, 64'(mem_be), 0);
        checkOutput({tag, "_mem_wdata"}, 64'(mem_wdata), 0);
        checkOutput({tag, "_out_valid"}, 64'(out_valid), 0);
        checkOutput({tag, "_out_inst"}, 64'(out_inst), 0);
        checkOutput({tag, "_out_rd"}, 64'(out_rd), 0);
        checkOutput({tag, "_out_rd_we"}, 64'(out_rd_we), 0);
        checkOutput({tag, "_out_data"}, 64'(out_data), 0);
        checkOutput({tag, "_out_exc"}, 64'(out_exc), 0);
    endtask

    function automatic int accessBytes(input bit store, input logic [2:0] f3);
        if (store) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    endfunction

    task automatic applyStimulus(input logic [6:0] opcode, input logic [2:0] f3, input logic [4:0] rd,
                                 input logic [31:0] a, input logic [31:0] d, input int ackDelay,
                                 input logic [31:0] rdata, input int stall);
        logic [31:0] word, expBe, expW, mask, raw;
        bit isLd, isSt, mis, expTrap, expRdWe;
        int n, off, lane;
        word  = {17'h0, f3, rd, opcode};
        isLd  = (opcode == OPC_LOAD);
        isSt  = (opcode == OPC_STORE);
        n     = accessBytes(isSt, f3);
        off   = int'(a % 4);
        lane  = off - (off % n);
        mis   = (off % n) != 0;
        expBe = ((32'd1 << n) - 1) << lane;
        for (int i = 0; i < 4; i++) expW[8*i +: 8] = d[8*(i % n) +: 8];
        mask  = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 1);
        raw   = (rdata >> (8 * lane)) & mask;
        if (!(f3 == 3'd4 || f3 == 3'd5) && n < 4 && raw[8*n-1]) raw = raw | ~mask;
        expTrap = 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        expTrap = (isLd || isSt) && mis;
`endif

        @(negedge clock);
        checkOutput("in_ready_idle", 64'(in_ready), 1);
        in_valid = 1'b1; inst = word; addr = a; wdata = d;
        @(negedge clock);
        in_valid = 1'b0; inst = $urandom; addr = $urandom; wdata = $urandom;

        if (!(isLd || isSt)) begin
            expRdWe = !(opcode == OPC_BR || opcode == OPC_FENCE) && rd != 5'd0;
            checkOutput("alu_valid", 64'(out_valid), 1);
            checkOutput("alu_data", 64'(out_data), 64'(d));
            checkOutput("alu_rd_we", 64'(out_rd_we), 64'(expRdWe));
            checkOutput("alu_rd", 64'(out_rd), 64'(rd));
            checkOutput("alu_inst", 64'(out_inst), 64'(word));
            checkOutput("alu_no_req", 64'(mem_req), 0);
        end else if (expTrap) begin
            checkOutput("trap_no_req", 64'(mem_req), 0);
            checkOutput("trap_valid", 64'(out_valid), 1);
            checkOutput("trap_exc", 64'(out_exc), 1);
            checkOutput("trap_rd_we", 64'(out_rd_we), 0);
            checkOutput("trap_data", 64'(out_data), 64'(a));
        end else begin
            checkOutput("mem_req_up", 64'(mem_req), 1);
            checkOutput("mem_we", 64'(mem_we), 64'(isSt));
            checkOutput("mem_addr", 64'(mem_addr), 64'({a[31:2], 2'b00}));
            checkOutput("mem_be", 64'(mem_be), 64'(expBe));
            if (isSt) checkOutput("mem_wdata", 64'(mem_wdata), 64'(expW));
            checkOutput("busy_no_valid", 64'(out_valid), 0);
            checkOutput("busy_in_ready", 64'(in_ready), 0);
            for (int c = 0; c < ackDelay; c++) begin
                mem_rdata = $urandom;
                @(negedge clock);
                checkOutput("req_held", 64'(mem_req), 1);
                checkOutput("addr_held", 64'(mem_addr), 64'({a[31:2], 2'b00}));
                checkOutput("wait_in_ready", 64'(in_ready), 0);
            end
            mem_ack = 1'b1; mem_rdata = rdata; out_ready = (stall == 0);
            @(negedge clock);
            mem_ack = 1'b0; mem_rdata = $urandom;
            checkOutput("req_dropped", 64'(mem_req), 0);
            checkOutput("wb_valid", 64'(out_valid), 1);
            checkOutput("wb_exc", 64'(out_exc), 0);
            checkOutput("wb_rd_we", 64'(out_rd_we), 64'(isLd && rd != 5'd0));
            checkOutput("wb_rd", 64'(out_rd), 64'(rd));
            checkOutput("wb_inst", 64'(out_inst), 64'(word));
            if (isLd) checkOutput("wb_load_data", 64'(out_data), 64'(raw));
            for (int c = 0; c < stall; c++) begin
                @(negedge clock);
                checkOutput("hold_valid", 64'(out_valid), 1);
                checkOutput("hold_in_ready", 64'(in_ready), 0);
                if (isLd) checkOutput("hold_data", 64'(out_data), 64'(raw));
            end
        end
        out_ready = 1'b1;
        @(negedge clock);
        checkOutput("consumed", 64'(out_valid), 0);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [6:0] aluOps [5];
        aluOps = '{7'b0110011, 7'b0010011, 7'b0110111, OPC_BR, OPC_FENCE};
        reset = 1'b1; in_valid = 1'b0; inst = '0; addr = '0; wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0; out_ready = 1'b0;
        repeat (3) @(negedge clock);
        checkResetValues("reset");
        checkOutput("reset_in_ready", 64'(in_ready), 1);
        reset = 1'b0;

        applyStimulus(OPC_LOAD, 3'd0, 5'd10, 32'h0000_1003, 32'h0, 0, 32'h80FF_FF00, 0);
        applyStimulus(OPC_STORE, 3'd1, 5'd2, 32'h0000_2002, 32'h0000_BEEF, 0, 32'h0, 0);
        applyStimulus(7'b0110011, 3'd0, 5'd5, 32'h0, 32'h0000_1234, 0, 32'h0, 0);
        applyStimulus(OPC_LOAD, 3'd2, 5'd7, 32'h0000_0100, 32'h0, 4, 32'hCAFE_F00D, 3);
        applyStimulus(OPC_LOAD, 3'd2, 5'd8, 32'h0000_3002, 32'h0, 1, 32'h1357_9BDF, 0);

        // Reset lands on the second BUSY cycle; the ack after it must be ignored.
        @(negedge clock);
        in_valid = 1'b1; inst = {17'h0, 3'd2, 5'd3, OPC_LOAD}; addr = 32'h40; wdata = '0;
        @(negedge clock);
        in_valid = 1'b0;
        checkOutput("rst_busy_req", 64'(mem_req), 1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        checkResetValues("midbusy");
        @(negedge clock);
        mem_ack = 1'b0;
        checkOutput("rst_in_ready", 64'(in_ready), 1);
        for (int c = 0; c < 3; c++) begin
            checkOutput("rst_no_valid", 64'(out_valid), 0);
            checkOutput("rst_no_req", 64'(mem_req), 0);
            @(negedge clock);
        end

        for (int t = 0; t < 200; t++) begin
            int kind;
            logic [6:0] op;
            kind = $urandom_range(0, 2);
            op = (kind == 0) ? aluOps[$urandom_range(0, 4)] : (kind == 1) ? OPC_LOAD : OPC_STORE;
            applyStimulus(op, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), $urandom, $urandom,
                          $urandom_range(0, 3), $urandom, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
